// File: rtl/ac_actuator_guard.sv
// Heater/cooler enable guard: min-on, min-off lockout and power-up lockout, never both on.
// Optional runtime counters (heat_cycles/cool_cycles) are built when AC_RUNTIME_CNT_EN is defined.
module ac_actuator_guard #(
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 8,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        heat_req,
  input  logic        cool_req,
  output logic        heater_on,
  output logic        cooler_on,
  output logic        busy,
`ifdef AC_RUNTIME_CNT_EN
  output logic [15:0] heat_cycles,
  output logic [15:0] cool_cycles,
`endif
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             heater_on_q, heater_on_d;
  logic             cooler_on_q, cooler_on_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             req_h, req_c, timer_nz;

  assign req_h    = heat_req & ~cool_req;
  assign req_c    = cool_req & ~heat_req;
  assign timer_nz = (timer_q != '0);

  // Next-state and timer; LOCK with an expired timer behaves as OFF on the same edge.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_OFF, ST_LOCK: begin
        if ((state_q == ST_LOCK) && timer_nz) begin
          timer_d = timer_q - ONE;
        end else if (req_h) begin
          state_d = ST_HEAT;
          timer_d = ON_LOAD;
        end else if (req_c) begin
          state_d = ST_COOL;
          timer_d = ON_LOAD;
        end else begin
          state_d = ST_OFF;
          timer_d = timer_q;
        end
      end
      ST_HEAT, ST_COOL: begin
        if (timer_nz) begin
          timer_d = timer_q - ONE;
        end else if (((state_q == ST_HEAT) && !req_h) || ((state_q == ST_COOL) && !req_c)) begin
          state_d = ST_LOCK;
          timer_d = OFF_LOAD;
        end else begin
          state_d = state_q;
          timer_d = timer_q;
        end
      end
      default: begin
        state_d = ST_LOCK;
        timer_d = OFF_LOAD;
      end
    endcase
  end

  // Output decodes taken from the next state so they land in flops alongside it.
  always_comb begin
    heater_on_d = (state_d == ST_HEAT);
    cooler_on_d = (state_d == ST_COOL);
    busy_d      = (state_d == ST_LOCK) |
                  (((state_d == ST_HEAT) | (state_d == ST_COOL)) & (timer_d != '0));
    fault_d     = heat_req & cool_req;
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOCK;
      timer_q     <= OFF_LOAD;
      heater_on_q <= 1'b0;
      cooler_on_q <= 1'b0;
      busy_q      <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      heater_on_q <= heater_on_d;
      cooler_on_q <= cooler_on_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  assign heater_on = heater_on_q;
  assign cooler_on = cooler_on_q;
  assign busy      = busy_q;
  assign fault     = fault_q;

`ifdef AC_RUNTIME_CNT_EN
  logic [15:0] heat_cycles_q, heat_cycles_d;
  logic [15:0] cool_cycles_q, cool_cycles_d;

  // Saturating on-time counters.
  always_comb begin
    heat_cycles_d = heat_cycles_q;
    cool_cycles_d = cool_cycles_q;
    if (heater_on_q && (heat_cycles_q != 16'hFFFF)) begin
      heat_cycles_d = heat_cycles_q + 16'd1;
    end else begin
      heat_cycles_d = heat_cycles_q;
    end
    if (cooler_on_q && (cool_cycles_q != 16'hFFFF)) begin
      cool_cycles_d = cool_cycles_q + 16'd1;
    end else begin
      cool_cycles_d = cool_cycles_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      heat_cycles_q <= 16'd0;
      cool_cycles_q <= 16'd0;
    end else begin
      heat_cycles_q <= heat_cycles_d;
      cool_cycles_q <= cool_cycles_d;
    end
  end

  assign heat_cycles = heat_cycles_q;
  assign cool_cycles = cool_cycles_q;
`endif

endmodule

// File: tb/tb_ac_actuator_guard.sv
// Directed bench for ac_actuator_guard (MIN_ON=8, MIN_OFF=8); outputs checked as {heater,cooler,busy,fault}.
module tb_ac_actuator_guard;

  logic clk = 1'b0;
  logic rst, heat_req, cool_req;
  logic heater_on, cooler_on, busy, fault;
`ifdef AC_RUNTIME_CNT_EN
  logic [15:0] heat_cycles, cool_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  ac_actuator_guard #(.MIN_ON(8), .MIN_OFF(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .heat_req  (heat_req),
    .cool_req  (cool_req),
    .heater_on (heater_on),
    .cooler_on (cooler_on),
    .busy      (busy),
`ifdef AC_RUNTIME_CNT_EN
    .heat_cycles (heat_cycles),
    .cool_cycles (cool_cycles),
`endif
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // n edges, checking outputs 1 time unit after each edge
  task automatic run(input string tag, input int n, input logic [3:0] exp);
    logic [3:0] obs;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs = {heater_on, cooler_on, busy, fault};
      n_cmp++;
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s[%0d]: observed %b expected %b (heater,cooler,busy,fault)", tag, i, obs, exp);
      end
    end
  endtask

`ifdef AC_RUNTIME_CNT_EN
  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    // 1: power-up lockout with heat_req held
    rst = 1'b1; heat_req = 1'b1; cool_req = 1'b0;
    run("t1_rst", 2, 4'b0010);
`ifdef AC_RUNTIME_CNT_EN
    chk16("t1_heat_cycles", heat_cycles, 16'd0);
`endif
    rst = 1'b0;
    run("t1_lock", 7, 4'b0010);
    run("t1_on", 1, 4'b1010);
    heat_req = 1'b0;
    run("t1_minon", 6, 4'b1010);
    run("t1_t0", 1, 4'b1000);
    run("t1_lockout", 8, 4'b0010);
    run("t1_off", 1, 4'b0000);

    // 2: single-cycle heat pulse
    heat_req = 1'b1;
    run("t2_on", 1, 4'b1010);
    heat_req = 1'b0;
    run("t2_minon", 6, 4'b1010);
    run("t2_t0", 1, 4'b1000);
    run("t2_lockout", 8, 4'b0010);
    run("t2_off", 1, 4'b0000);

    // 3: cool held 20 cycles
    cool_req = 1'b1;
    run("t3_on", 7, 4'b0110);
    run("t3_hold", 13, 4'b0100);
    cool_req = 1'b0;
    run("t3_release", 8, 4'b0010);
    run("t3_off", 1, 4'b0000);

    // 4: heat -> cool changeover after min-on
    heat_req = 1'b1;
    run("t4_heat", 7, 4'b1010);
    run("t4_hold", 3, 4'b1000);
    heat_req = 1'b0; cool_req = 1'b1;
    run("t4_gap", 8, 4'b0010);
    run("t4_cool", 7, 4'b0110);
    cool_req = 1'b0;
    run("t4_cool_t0", 1, 4'b0100);
    run("t4_lockout", 8, 4'b0010);
    run("t4_off", 1, 4'b0000);

    // 5: conflicting requests in OFF, then in HEAT
    heat_req = 1'b1; cool_req = 1'b1;
    run("t5_off_fault", 3, 4'b0001);
    heat_req = 1'b0; cool_req = 1'b0;
    run("t5_fault_clr", 1, 4'b0000);
    heat_req = 1'b1;
    run("t5_heat", 1, 4'b1010);
    cool_req = 1'b1;
    run("t5_heat_fault", 6, 4'b1011);
    run("t5_heat_t0", 1, 4'b1001);
    run("t5_exit", 1, 4'b0011);
    heat_req = 1'b0; cool_req = 1'b0;
    run("t5_lockout", 7, 4'b0010);
    run("t5_off", 1, 4'b0000);

    // 6: reset three cycles into HEAT
    heat_req = 1'b1;
    run("t6_heat", 3, 4'b1010);
    rst = 1'b1;
    run("t6_rst", 1, 4'b0010);
`ifdef AC_RUNTIME_CNT_EN
    chk16("t6_heat_cycles", heat_cycles, 16'd0);
`endif
    rst = 1'b0;
    run("t6_lock", 7, 4'b0010);
    run("t6_on", 1, 4'b1010);
    heat_req = 1'b0;
    run("t6_minon", 6, 4'b1010);
    run("t6_t0", 1, 4'b1000);
    run("t6_lockout", 8, 4'b0010);
    run("t6_off", 1, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
